// File: rtl/alu_exec_stage.sv
// Execute stage: ARM condition check, single-cycle data-processing ALU and
// iterative shift-add multiply; owns the architectural NZCV flags.
module alu_exec_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  cond,
   input  logic [3:0]  alu_op,
   input  logic        set_flags,
   input  logic        is_mul,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [3:0]  rd_in,
   output logic [31:0] result,
   output logic [3:0]  rd_out,
   output logic        reg_we,
   output logic [3:0]  flags,
   output logic        busy,
   output logic        done
);

   localparam int CNT_W = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

   logic [0:0]       state;
   logic [CNT_W-1:0] mul_cnt;
   logic [31:0]      mcand;
   logic [31:0]      mplier;
   logic [31:0]      acc;
   logic [31:0]      acc_next;
   logic [3:0]       mul_rd;
   logic             mul_s;

   logic        cond_pass;
   logic        is_test;
   logic        is_arith;
   logic [31:0] add_x;
   logic [31:0] add_y;
   logic        add_cin;
   logic [32:0] sum;
   logic [31:0] alu_res;
   logic [3:0]  alu_flags;

   wire fn = flags[3];
   wire fz = flags[2];
   wire fc = flags[1];
   wire fv = flags[0];

   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'h0: cond_pass = fz;
         4'h1: cond_pass = !fz;
         4'h2: cond_pass = fc;
         4'h3: cond_pass = !fc;
         4'h4: cond_pass = fn;
         4'h5: cond_pass = !fn;
         4'h6: cond_pass = fv;
         4'h7: cond_pass = !fv;
         4'h8: cond_pass = fc && !fz;
         4'h9: cond_pass = !fc || fz;
         4'hA: cond_pass = (fn == fv);
         4'hB: cond_pass = (fn != fv);
         4'hC: cond_pass = !fz && (fn == fv);
         4'hD: cond_pass = fz || (fn != fv);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Every arithmetic op is folded onto one adder as x + y + cin; subtracts
   // invert the subtrahend so the adder carry-out is NOT borrow.
   always_comb begin
      add_x    = src_a;
      add_y    = src_b;
      add_cin  = 1'b0;
      is_arith = 1'b1;
      case (alu_op)
         OP_SUB, OP_CMP: begin add_y = ~src_b; add_cin = 1'b1; end
         OP_RSB:         begin add_x = src_b; add_y = ~src_a; add_cin = 1'b1; end
         OP_ADD, OP_CMN: add_cin = 1'b0;
         OP_ADC:         add_cin = fc;
         OP_SBC:         begin add_y = ~src_b; add_cin = fc; end
         OP_RSC:         begin add_x = src_b; add_y = ~src_a; add_cin = fc; end
         default:        is_arith = 1'b0;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
   end

   always_comb begin
      alu_res = sum[31:0];
      case (alu_op)
         OP_AND, OP_TST: alu_res = src_a & src_b;
         OP_EOR, OP_TEQ: alu_res = src_a ^ src_b;
         OP_ORR:         alu_res = src_a | src_b;
         OP_MOV:         alu_res = src_b;
         OP_BIC:         alu_res = src_a & ~src_b;
         OP_MVN:         alu_res = ~src_b;
         default:        alu_res = sum[31:0];
      endcase
      is_test      = (alu_op[3:2] == 2'b10);
      alu_flags[3] = alu_res[31];
      alu_flags[2] = (alu_res == 32'd0);
      alu_flags[1] = is_arith ? sum[32] : fc;
      alu_flags[0] = is_arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : fv;
   end

   assign acc_next = acc + (mplier[0] ? mcand : 32'd0);

   // Issue decode in IDLE; in MUL one shift-add step per edge until the last
   // iteration writes back. start is ignored whenever the multiplier is busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         mul_cnt <= '0;
         mcand   <= 32'd0;
         mplier  <= 32'd0;
         acc     <= 32'd0;
         mul_rd  <= 4'd0;
         mul_s   <= 1'b0;
         result  <= 32'd0;
         rd_out  <= 4'd0;
         reg_we  <= 1'b0;
         flags   <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done   <= 1'b0;
         reg_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (!cond_pass) begin
                     done <= 1'b1;
                  end else if (is_mul) begin
                     mcand   <= src_a;
                     mplier  <= src_b;
                     acc     <= 32'd0;
                     mul_cnt <= '0;
                     mul_rd  <= rd_in;
                     mul_s   <= set_flags;
                     busy    <= 1'b1;
                     state   <= ST_MUL;
                  end else begin
                     if (!is_test) begin
                        result <= alu_res;
                        rd_out <= rd_in;
                        reg_we <= 1'b1;
                     end
                     if (set_flags || is_test)
                        flags <= alu_flags;
                     done <= 1'b1;
                  end
               end
            end
            default: begin
               acc     <= acc_next;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               mul_cnt <= mul_cnt + 1'b1;
               if (mul_cnt == LAST_ITER) begin
                  result  <= acc_next;
                  rd_out  <= mul_rd;
                  reg_we  <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  mul_cnt <= '0;
                  state   <= ST_IDLE;
                  if (mul_s)
                     flags[3:2] <= {acc_next[31], (acc_next == 32'd0)};
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors checked with
// immediate assertions after each issue.
module tb_alu_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  cond;
   logic [3:0]  alu_op;
   logic        set_flags;
   logic        is_mul;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [3:0]  rd_in;
   logic [31:0] result;
   logic [3:0]  rd_out;
   logic        reg_we;
   logic [3:0]  flags;
   logic        busy;
   logic        done;

   int num_asserts = 0;
   int num_fail    = 0;
   int early_done;
   int busy_drop;
   int we_seen;

   alu_exec_stage #(.MUL_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cond(cond), .alu_op(alu_op),
      .set_flags(set_flags), .is_mul(is_mul), .src_a(src_a), .src_b(src_b),
      .rd_in(rd_in), .result(result), .rd_out(rd_out), .reg_we(reg_we),
      .flags(flags), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_asserts++;
      assert (obs === exp)
      else begin
         num_fail++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one instruction for a single edge, then sample #1 after it.
   task automatic applyStimulus(input logic [3:0] c, input logic [3:0] op, input logic s,
                                input logic m, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] rd);
      cond = c; alu_op = op; set_flags = s; is_mul = m;
      src_a = a; src_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic checkStep(input string tag, input logic [31:0] res, input logic [3:0] rd,
                            input logic we, input logic [3:0] nzcv);
      checkOutput({tag, ".done"},   {31'd0, done},   32'd1);
      checkOutput({tag, ".reg_we"}, {31'd0, reg_we}, {31'd0, we});
      checkOutput({tag, ".result"}, result,          res);
      checkOutput({tag, ".rd_out"}, {28'd0, rd_out}, {28'd0, rd});
      checkOutput({tag, ".flags"},  {28'd0, flags},  {28'd0, nzcv});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cond = 4'hE; alu_op = 4'h0; set_flags = 1'b0;
      is_mul = 1'b0; src_a = 32'd0; src_b = 32'd0; rd_in = 4'd0;
      #1;
      checkOutput("reset.result", result, 32'd0);
      checkOutput("reset.flags",  {28'd0, flags}, 32'd0);
      checkOutput("reset.busy",   {31'd0, busy},  32'd0);
      checkOutput("reset.done",   {31'd0, done},  32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(4'hE, 4'h4, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'd1);
      checkStep("adds_wrap", 32'h0, 4'd1, 1'b1, 4'b0110);
      applyStimulus(4'hE, 4'h4, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1, 4'd2);
      checkStep("adds_ovf", 32'h8000_0000, 4'd2, 1'b1, 4'b1001);
      applyStimulus(4'hE, 4'h2, 1'b1, 1'b0, 32'd5, 32'd7, 4'd4);
      checkStep("subs", 32'hFFFF_FFFE, 4'd4, 1'b1, 4'b1000);
      applyStimulus(4'hE, 4'hA, 1'b0, 1'b0, 32'd9, 32'd9, 4'd5);
      checkStep("cmp_eq", 32'hFFFF_FFFE, 4'd4, 1'b0, 4'b0110);
      applyStimulus(4'h1, 4'h4, 1'b1, 1'b0, 32'd2, 32'd2, 4'd3);
      checkStep("addne_fail", 32'hFFFF_FFFE, 4'd4, 1'b0, 4'b0110);
      applyStimulus(4'h0, 4'h4, 1'b0, 1'b0, 32'd2, 32'd2, 4'd3);
      checkStep("addeq", 32'd4, 4'd3, 1'b1, 4'b0110);
      @(posedge clk); #1;
      checkOutput("pulse.done",   {31'd0, done},   32'd0);
      checkOutput("pulse.reg_we", {31'd0, reg_we}, 32'd0);
      applyStimulus(4'hE, 4'h5, 1'b1, 1'b0, 32'd1, 32'd1, 4'd6);
      checkStep("adcs", 32'd3, 4'd6, 1'b1, 4'b0000);
      applyStimulus(4'hE, 4'h0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd7);
      checkStep("and", 32'h00F0_00F0, 4'd7, 1'b1, 4'b0000);

      // Multiply with a stray start mid-way that must be ignored.
      applyStimulus(4'hE, 4'h0, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0010, 4'd8);
      checkOutput("mul.busy_start", {31'd0, busy}, 32'd1);
      checkOutput("mul.done_start", {31'd0, done}, 32'd0);
      early_done = 0; busy_drop = 0;
      for (int i = 1; i <= 31; i++) begin
         if (i == 5) begin
            cond = 4'hE; alu_op = 4'h4; is_mul = 1'b0; src_a = 32'd1; src_b = 32'd1;
            rd_in = 4'd9; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done || reg_we) early_done++;
         if (!busy) busy_drop++;
      end
      checkOutput("mul.early_done", early_done, 32'd0);
      checkOutput("mul.busy_held",  busy_drop,  32'd0);
      @(posedge clk); #1;
      checkStep("mul", 32'h0001_2340, 4'd8, 1'b1, 4'b0000);
      checkOutput("mul.busy_end", {31'd0, busy}, 32'd0);

      applyStimulus(4'hE, 4'h4, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 4'd10);
      checkStep("adds_cv", 32'h0, 4'd10, 1'b1, 4'b0111);
      applyStimulus(4'hE, 4'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 4'd11);
      repeat (32) @(posedge clk);
      #1;
      checkStep("muls", 32'hFFFF_FFFE, 4'd11, 1'b1, 4'b1011);

      applyStimulus(4'hA, 4'hD, 1'b0, 1'b0, 32'd0, 32'h55, 4'd7);
      checkStep("movge", 32'h55, 4'd7, 1'b1, 4'b1011);
      applyStimulus(4'hB, 4'h4, 1'b1, 1'b0, 32'd1, 32'd1, 4'd2);
      checkStep("addlt_fail", 32'h55, 4'd7, 1'b0, 4'b1011);
      applyStimulus(4'hF, 4'h4, 1'b1, 1'b0, 32'd1, 32'd1, 4'd2);
      checkStep("nv_fail", 32'h55, 4'd7, 1'b0, 4'b1011);
      applyStimulus(4'hE, 4'h3, 1'b1, 1'b0, 32'd1, 32'd0, 4'd12);
      checkStep("rsbs", 32'hFFFF_FFFF, 4'd12, 1'b1, 4'b1000);
      applyStimulus(4'hE, 4'h6, 1'b1, 1'b0, 32'd10, 32'd3, 4'd12);
      checkStep("sbcs", 32'd6, 4'd12, 1'b1, 4'b0010);
      applyStimulus(4'hE, 4'h9, 1'b0, 1'b0, 32'd5, 32'd5, 4'd1);
      checkStep("teq", 32'd6, 4'd12, 1'b0, 4'b0110);
      applyStimulus(4'hE, 4'hF, 1'b1, 1'b0, 32'd0, 32'd0, 4'd13);
      checkStep("mvns", 32'hFFFF_FFFF, 4'd13, 1'b1, 4'b1010);
      applyStimulus(4'hE, 4'hE, 1'b0, 1'b0, 32'hFF, 32'h0F, 4'd14);
      checkStep("bic", 32'hF0, 4'd14, 1'b1, 4'b1010);

      // Reset ten cycles into a multiply: aborted with no write-back.
      applyStimulus(4'hE, 4'h0, 1'b1, 1'b1, 32'd3, 32'd3, 4'd15);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort.busy",   {31'd0, busy},  32'd0);
      checkOutput("abort.flags",  {28'd0, flags}, 32'd0);
      checkOutput("abort.result", result,         32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      we_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (reg_we || done || busy) we_seen++;
      end
      checkOutput("abort.no_write", we_seen, 32'd0);
      applyStimulus(4'hE, 4'h4, 1'b0, 1'b0, 32'd3, 32'd4, 4'd5);
      checkStep("add_after_abort", 32'd7, 4'd5, 1'b1, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the register file. Consumes the two read operands, evaluates the ARM condition field against an internal NZCV flags register, and performs the data-processing op or an iterative 32x32 multiply.
- Returns the result, destination index and write-enable to the register file write port.
- Owns the architectural NZCV flags.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for multiply (equals operand width; fixed at 32 for this design).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe; instruction fields below valid this cycle.
- cond  in  4  ARM condition field, instr[31:28].
- alu_op  in  4  ARM data-processing opcode, instr[24:21].
- set_flags  in  1  S bit.
- is_mul  in  1  1 = MUL instruction; alu_op ignored.
- src_a  in  32  operand Rn (RD1).
- src_b  in  32  operand Rm or immediate (RD2 path).
- rd_in  in  4  destination register index.
- result  out  32  registered result, to WD3.
- rd_out  out  4  registered destination, to A3.
- reg_we  out  1  write strobe, to WE3.
- flags  out  4  NZCV, bit3 = N.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, asynchronous): result=0, rd_out=0, reg_we=0, flags=0000, busy=0, done=0, state=IDLE, iteration counter=0. Reset asserted mid-multiply aborts the multiply with no write and no flag change.
- States: IDLE and MUL.
- Condition check is done at the start edge against current flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1110 passes; 1111 always fails.
- Condition fail: at the start edge, done=1, reg_we=0; result, rd_out and flags are unchanged. No MUL entry.
- ALU op (is_mul=0, condition pass), single-cycle: computed from src_a/src_b and registered at the start edge. done=1 and result/rd_out valid the following cycle.
  - reg_we=1 except for TST/TEQ/CMP/CMN, which force reg_we=0.
- Op set: AND, EOR, SUB(a-b), RSB(b-a), ADD, ADC(a+b+C), SBC(a-b-!C), RSC(b-a-!C), TST, TEQ, CMP, CMN, ORR, MOV(b), BIC(a&~b), MVN(~b).
- Flag update occurs if set_flags=1, or unconditionally for TST/TEQ/CMP/CMN:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry out of the 33-bit sum. Subtract-type ops compute a+~b+cin, so C = NOT borrow. V = signed overflow of the 32-bit sum.
  - Logical ops: C and V preserved (no shifter carry in this stage).
- MUL (is_mul=1, condition pass):
  - Start edge: latch operands, clear accumulator, counter=0, busy=1, state=MUL.
  - Each subsequent edge: if multiplier LSB is set, add multiplicand to accumulator; then shift multiplicand left and multiplier right; counter++.
  - On the edge where counter reaches MUL_CYCLES-1 (the 32nd iteration edge after start): result = low 32 bits of the product, rd_out = latched rd, reg_we=1, done=1, busy=0, state=IDLE.
  - Start-to-done latency is 32 cycles.
  - If set_flags: update N and Z from the result; C and V preserved.
- start while busy=1 is ignored (no latch, no effect). The issuer must hold off on busy.
- done and reg_we are single-cycle pulses. result, rd_out and flags hold between operations.
- start in the same cycle that the multiply completes is ignored, because busy is still 1 in that cycle.
- All arithmetic is modulo 2^32. The product is truncated to 32 bits.

Test Plan:
- Reset flags=0000. Issue ADDS AL: a=0xFFFFFFFF, b=0x00000001 -> next cycle result=0x00000000, reg_we=1, done=1, flags=0110. Then ADDS a=0x7FFFFFFF, b=1 -> result=0x80000000, flags=1001.
- SUBS a=5, b=7 -> result=0xFFFFFFFE, NZCV=1000. Follow with CMP a=9, b=9 -> reg_we=0, flags=0110, result unchanged.
- After CMP equal (Z=1): ADDNE rd=3 -> done=1, reg_we=0, flags unchanged. Then ADDEQ rd=3, a=2, b=2 -> result=4, rd_out=3, reg_we=1.
- With C=1, ADCS a=1, b=1 -> result=3, flags=0000. Then AND a=0xF0F0F0F0, b=0x0FF00FF0 with S=0 -> result=0x00F000F0, flags unchanged.
- MUL a=0x00001234, b=0x00000010 -> busy=1 for 32 cycles, done with result=0x00012340 exactly 32 cycles after start. A second start issued mid-multiply is ignored. MULS a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE, N=1, C and V preserved.
- Assert rst_n low 10 cycles into a MUL -> busy=0 and flags=0000 immediately. No reg_we pulse follows; the next ADD completes normally.
